// File: rtl/j1_pkg.sv
// Shared J1 definitions: code RAM geometry and the program loader state encoding.
package j1_pkg;

  localparam int         CODE_AW   = 13;
  localparam int         CODE_W    = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_DAT_LO = 3'd4,
    ST_CSUM   = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

endpackage

// File: rtl/j1_loader.sv
// Boot loader: receives a framed, XOR-checksummed program image over a byte
// stream, writes it into J1 code RAM and holds the core in reset until done.
module j1_loader
  import j1_pkg::*;
#(
  parameter int         ADDR_W = CODE_AW,
  parameter int         WIDTH  = CODE_W,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              skip,
  input  logic              load_req,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [WIDTH-1:0]  ld_data,
  output logic              cpu_resetq,
  output logic              busy,
  output logic              err
);

  // Word index is one bit wider than the RAM address so a full RAM image fits.
  localparam int          IW    = ADDR_W + 1;
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

  loader_state_t     state_r, state_s;
  logic [7:0]        cnt_hi_r, hi_r, xor_r;
  logic [IW-1:0]     cnt_r, idx_r;
  logic              ld_we_r, cpu_resetq_r, err_r;
  logic [ADDR_W-1:0] ld_addr_r;
  logic [WIDTH-1:0]  ld_data_r;
  logic              xfer_s, is_sync_s, last_s;
  logic [15:0]       n_s;

  assign rx_ready  = (state_r != ST_RUN);
  assign busy      = (state_r inside {ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO, ST_CSUM});
  assign xfer_s    = rx_valid && rx_ready;
  assign is_sync_s = (rx_data == SYNC);
  assign n_s       = {cnt_hi_r, rx_data};
  assign last_s    = ((idx_r + IW'(1)) == cnt_r);

  assign ld_we      = ld_we_r;
  assign ld_addr    = ld_addr_r;
  assign ld_data    = ld_data_r;
  assign cpu_resetq = cpu_resetq_r;
  assign err        = err_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (skip)                    state_s = ST_RUN;
        else if (xfer_s && is_sync_s) state_s = ST_CNT_HI;
        else                         state_s = state_r;
      end
      ST_CNT_HI: begin
        if (xfer_s) state_s = ST_CNT_LO;
        else        state_s = state_r;
      end
      ST_CNT_LO: begin
        if (!xfer_s)                   state_s = state_r;
        else if ({1'b0, n_s} > MAX_N)  state_s = ST_ERR;
        else if (n_s == 16'd0)         state_s = ST_CSUM;
        else                           state_s = ST_DAT_HI;
      end
      ST_DAT_HI: begin
        if (xfer_s) state_s = ST_DAT_LO;
        else        state_s = state_r;
      end
      ST_DAT_LO: begin
        if (!xfer_s)    state_s = state_r;
        else if (last_s) state_s = ST_CSUM;
        else            state_s = ST_DAT_HI;
      end
      ST_CSUM: begin
        if (!xfer_s)              state_s = state_r;
        else if (rx_data == xor_r) state_s = ST_RUN;
        else                      state_s = ST_ERR;
      end
      ST_RUN: begin
        if (load_req) state_s = ST_HUNT;
        else          state_s = state_r;
      end
      ST_ERR: begin
        if (xfer_s && is_sync_s) state_s = ST_CNT_HI;
        else                     state_s = state_r;
      end
      default: state_s = ST_HUNT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state_r <= ST_HUNT;
    else         state_r <= state_s;
  end

  // Byte assembly, checksum, write port and status outputs
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cnt_hi_r     <= 8'd0;
      hi_r         <= 8'd0;
      xor_r        <= 8'd0;
      cnt_r        <= '0;
      idx_r        <= '0;
      ld_we_r      <= 1'b0;
      ld_addr_r    <= '0;
      ld_data_r    <= '0;
      cpu_resetq_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      ld_we_r      <= 1'b0;
      cpu_resetq_r <= (state_s == ST_RUN);
      err_r        <= (state_s == ST_ERR);
      if (xfer_s) begin
        case (state_r)
          ST_HUNT, ST_ERR: begin
            if (is_sync_s) begin
              xor_r <= 8'd0;
              idx_r <= '0;
            end
          end
          ST_CNT_HI: begin
            cnt_hi_r <= rx_data;
            xor_r    <= xor_r ^ rx_data;
          end
          ST_CNT_LO: begin
            cnt_r <= n_s[IW-1:0];
            xor_r <= xor_r ^ rx_data;
          end
          ST_DAT_HI: begin
            hi_r  <= rx_data;
            xor_r <= xor_r ^ rx_data;
          end
          ST_DAT_LO: begin
            ld_we_r   <= 1'b1;
            ld_addr_r <= idx_r[ADDR_W-1:0];
            ld_data_r <= WIDTH'({hi_r, rx_data});
            idx_r     <= idx_r + IW'(1);
            xor_r     <= xor_r ^ rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/j1_loader.md
# j1_loader

Boot/program loader that sits between a byte-stream source (UART receiver) and the J1 core. It holds the core in reset, receives a framed program image, writes it word by word into code RAM through a write port, checks an XOR checksum, and releases the core. It returns to loading on request, so the core can be reprogrammed without a board reset.

## Interface
- `ADDR_W`, default 13: code RAM word-address width, matching the core's `code_addr`.
- `WIDTH`, default 16: code word width.
- `SYNC`, default 8'hA5: frame start byte.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `resetq`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer happens on an edge with `rx_valid && rx_ready`.
- `skip`  in  1  in HUNT, release the core without loading (RAM preloaded).
- `load_req`  in  1  in RUN, return to HUNT and hold the core in reset.
- `ld_we`  out  1  code RAM write strobe, one cycle per word.
- `ld_addr`  out  ADDR_W  code RAM write address.
- `ld_data`  out  WIDTH  code RAM write data.
- `cpu_resetq`  out  1  active-low reset to the J1 core; high only in RUN.
- `busy`  out  1  a frame is in progress (CNT_HI..CSUM).
- `err`  out  1  last frame failed; sticky until the next SYNC.

## Operation
- Frame format: `SYNC`, count high byte, count low byte, then N words (each high byte then low byte), then the checksum byte.
- The checksum is the XOR of every byte after `SYNC` and before the checksum byte.
- States: HUNT, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM, RUN, ERR.
- HUNT: accepted byte == `SYNC` → CNT_HI, clear the running XOR and word index. Any other byte is discarded. `skip` → RUN; `skip` has priority over a byte on the same edge.
- CNT_HI → CNT_LO on an accepted byte. CNT_LO then decides:
  - N > 2^ADDR_W → ERR, no writes.
  - N == 0 → CSUM.
  - Otherwise → DAT_HI.
- DAT_HI: latch the high byte → DAT_LO.
- DAT_LO: latch the low byte. On the next edge `ld_we`=1 with `ld_addr`=word index and `ld_data`={hi,lo}, and the index increments.
  - Last word → CSUM; otherwise → DAT_HI.
- CSUM: byte == running XOR → RUN; mismatch → ERR. Words already written stay in RAM.
- ERR: `err`=1 and the core stays in reset. Accepted `SYNC` → CNT_HI and clears `err`; other bytes are discarded.
- RUN: `rx_ready`=0 (the stream belongs to the application). `load_req` → HUNT. `skip` and byte traffic are ignored.
- `load_req` is ignored outside RUN. `skip` is ignored outside HUNT.
- Word index is ADDR_W+1 bits wide and never wraps, because N is bounded at CNT_LO.

## Timing
- Reset values: state HUNT, `cpu_resetq`=0, `ld_we`=0, `ld_addr`=0, `ld_data`=0, `err`=0, `busy`=0, `rx_ready`=1.
- All outputs are registered except `rx_ready` and `busy`, which decode the current state.
- `rx_ready`=1 in every state except RUN. Gaps in `rx_valid` stall the FSM without losing partial words.
- Write latency: `ld_we` is high in the cycle after the edge that accepts a word's low byte.
- Back-to-back bytes give at most one write every 2 cycles; there is no write-port backpressure.
- `cpu_resetq` rises on the edge that enters RUN (CSUM match or `skip`). It falls on the edge that accepts `load_req`.
- The core therefore first sees reset released one cycle after the final `ld_we`, at the earliest.
- Async reset mid-frame: all outputs return to their reset values immediately. The frame is abandoned and the RAM contents are undefined.

## Structure
- Shared package `j1_pkg`:
  - state enum `loader_state_t`.
  - `SYNC_BYTE` default.
  - `CODE_AW`=13 and `CODE_W`=16, also used by the core and the RAM wrapper.
- Single module with no sub-modules. Byte assembly and the checksum are a few registers inside the FSM.

## Test plan
- Reset, then stream A5 00 02 12 34 56 78 0A.
  - Required: `ld_we` at addr 0 with data 1234, then at addr 1 with data 5678.
  - Then `cpu_resetq`=1, `rx_ready`=0, `err`=0.
- Same frame with checksum 0B.
  - Required: both writes occur, then `err`=1 and `cpu_resetq` stays 0.
  - A following A5 clears `err`, and `busy`=1.
- A5 20 01.
  - Required: enters ERR immediately after the count low byte, no `ld_we`.
- Frame A5 00 00 00 → RUN with no writes. Noise bytes 00 FF in HUNT are ignored.
  - `skip` in HUNT → `cpu_resetq`=1 on the next edge.
- Frame bytes with `rx_valid` gaps of 0–5 cycles.
  - Required: identical writes. `load_req` in RUN → `cpu_resetq`=0 and `rx_ready`=1 one edge later.
- Assert `resetq` low between DAT_HI and DAT_LO.
  - Required: outputs at reset values immediately, state HUNT after release, and the next full frame loads correctly.
